data_mem_arbiter: RTL and testbench

Shares the single data memory port between the core's load/store path and a secondary bus master (DMA/program loader). Sits between the core's memory-control signals and `data_memory`. Core accesses are serviced combinationally in the same cycle. The secondary master gets a valid/ready request channel with bursts, a starvation guard and a registered read response. `core_stall` tells the core to hold its PC and suppress register write-back.

---
 rtl/data_mem_arbiter_pkg.sv | 20 ++
 rtl/data_mem_arbiter_if.sv | 57 +++++
 rtl/data_mem_arbiter_starve.sv | 32 +++
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
// Purpose: memory access size encoding, arbiter FSM states and default limits.
// Ports: none (package).
package data_mem_arbiter_pkg;

  localparam int XLEN             = 32;
  localparam int DMA_ARB_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_DMA_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - core, DMA and memory-port signal bundle of the arbiter
// Purpose: groups the core load/store path, the DMA request/response channel and
//          the data_memory port into one interface.
// Modports: slave  - arbiter view (drives stall/ready/response and memory strobes)
//           master - environment view (core, DMA master and data_memory)
interface data_mem_arbiter_if;
  import data_mem_arbiter_pkg::*;

  // core load/store path
  logic             core_read;
  logic             core_write;
  mem_size_e        core_size;
  logic             core_unsigned;
  logic [XLEN-1:0]  core_addr;
  logic [XLEN-1:0]  core_wdata;
  logic [XLEN-1:0]  core_rdata;
  logic             core_stall;

  // secondary master request channel and read response
  logic             dma_valid;
  logic             dma_ready;
  logic             dma_we;
  logic             dma_burst;
  logic             dma_last;
  logic [XLEN-1:0]  dma_addr;
  logic [XLEN-1:0]  dma_wdata;
  logic             dma_rvalid;
  logic [XLEN-1:0]  dma_rdata;

  // data_memory port
  logic             mem_read;
  logic             mem_write;
  mem_size_e        mem_size;
  logic             mem_unsigned;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [XLEN-1:0]  mem_rdata;

  modport slave (
    input  core_read, core_write, core_size, core_unsigned, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dma_valid, dma_we, dma_burst, dma_last, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_read, mem_write, mem_size, mem_unsigned, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_read, core_write, core_size, core_unsigned, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dma_valid, dma_we, dma_burst, dma_last, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_read, mem_write, mem_size, mem_unsigned, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_starve.sv
// rtl/data_mem_arbiter_starve.sv - saturating wait counter for the DMA starvation guard
// Purpose: counts cycles a DMA request is blocked; o_at_max forces the next grant.
// Ports: clk, rst_n (async active-low), i_inc (blocked this cycle),
//        i_clr (accepted or no request, wins over i_inc), o_at_max (count == MAX_WAIT).
module arb_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the data memory port between the core and a DMA master
// Purpose: core accesses are granted combinationally; the DMA master gets a
//          valid/ready channel with bursts and a registered read response.
//          Optional starvation guard: DATA_MEM_ARB_STARVE_GUARD_EN.
// Ports: clk, rst_n (async active-low), bus (data_mem_arbiter_if.slave):
//        core_* load/store path with core_stall, dma_* request/response channel,
//        mem_* port to data_memory.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
#(
  parameter int MAX_WAIT = DMA_ARB_MAX_WAIT
)
`endif
(
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   bus
);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic             r_rvalid;
  logic [XLEN-1:0]  r_rdata;

  logic             w_core_pend;
  logic             w_force;
  logic             w_dma_sel;
  logic             w_dma_accept;

  assign w_core_pend = bus.core_read | bus.core_write;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (bus.dma_valid && !w_dma_accept),
    .i_clr    (w_dma_accept || !bus.dma_valid),
    .o_at_max (w_force)
  );
`else
  assign w_force = 1'b0;
`endif

  // A burst keeps the port even across dma_valid gaps, so the core stays stalled.
  assign w_dma_sel    = (r_state == ARB_DMA_BURST) ||
                        (bus.dma_valid && (!w_core_pend || w_force));
  assign w_dma_accept = rst_n && w_dma_sel && bus.dma_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_dma_accept && bus.dma_burst && !bus.dma_last) begin
          w_next_state = ARB_DMA_BURST;
        end
      end
      ARB_DMA_BURST: begin
        // dma_burst is not looked at here: only dma_last ends the burst.
        if (w_dma_accept && bus.dma_last) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Memory port mux; DMA accesses are always unsigned-agnostic full words.
  always_comb begin
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = MEM_WORD;
    bus.mem_unsigned = 1'b0;
    bus.mem_addr     = bus.core_addr;
    bus.mem_wdata    = bus.core_wdata;
    if (w_dma_sel) begin
      bus.mem_read  = bus.dma_valid && !bus.dma_we;
      bus.mem_write = bus.dma_valid && bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end else begin
      bus.mem_read     = bus.core_read;
      bus.mem_write    = bus.core_write;
      bus.mem_size     = bus.core_size;
      bus.mem_unsigned = bus.core_unsigned;
    end
    if (!rst_n) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_dma_accept && !bus.dma_we) begin
      r_rvalid <= 1'b1;
      r_rdata  <= bus.mem_rdata;
    end else begin
      r_rvalid <= 1'b0;
    end
  end

  assign bus.dma_ready  = w_dma_accept;
  assign bus.core_stall = rst_n && w_core_pend && w_dma_sel;
  assign bus.core_rdata = w_dma_sel ? '0 : bus.mem_rdata;
  assign bus.dma_rvalid = r_rvalid;
  assign bus.dma_rdata  = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i));
  endfunction

  // data_memory stand-in: combinational read, write on the clock edge
  logic [31:0] tb_mem [0:255];
  logic        mem_init_done = 1'b0;
  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_write) begin
      tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [0:255];
  logic        ref_init = 1'b0;
  logic        m_burst  = 1'b0;
  int          m_wait   = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata  = 32'h0;

  // Who owns the memory port this cycle according to the arbitration rules.
  function automatic logic dma_owns();
    logic core_busy;
    logic starved;
    core_busy = bus.core_read || bus.core_write;
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
    starved = (m_wait >= MAXW);
`else
    starved = 1'b0;
`endif
    if (m_burst) return 1'b1;
    return bus.dma_valid && (!core_busy || starved);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_burst  <= 1'b0;
      m_wait   <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
    end else begin
      if (dma_owns() && bus.dma_valid) begin
        m_wait <= 0;
        if (!bus.dma_we) begin
          m_rvalid <= 1'b1;
          m_rdata  <= ref_mem[bus.dma_addr[9:2]];
        end else begin
          m_rvalid <= 1'b0;
        end
        if (!m_burst && bus.dma_burst && !bus.dma_last) m_burst <= 1'b1;
        if (m_burst && bus.dma_last) m_burst <= 1'b0;
      end else begin
        m_rvalid <= 1'b0;
        m_wait   <= bus.dma_valid ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= init_word(i);
      ref_init <= 1'b1;
    end else if (rst_n) begin
      if (dma_owns()) begin
        if (bus.dma_valid && bus.dma_we) ref_mem[bus.dma_addr[9:2]] <= bus.dma_wdata;
      end else if (bus.core_write) begin
        ref_mem[bus.core_addr[9:2]] <= bus.core_wdata;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (ref_init) begin
      if (!rst_n) begin
        check("rst_ready", {31'b0, bus.dma_ready}, 32'd0);
        check("rst_stall", {31'b0, bus.core_stall}, 32'd0);
        check("rst_mread", {31'b0, bus.mem_read}, 32'd0);
        check("rst_mwrite", {31'b0, bus.mem_write}, 32'd0);
      end else begin
        logic own;
        logic e_rd;
        logic e_wr;
        own  = dma_owns();
        e_rd = own ? (bus.dma_valid && !bus.dma_we) : bus.core_read;
        e_wr = own ? (bus.dma_valid && bus.dma_we) : bus.core_write;
        check("m_ready", {31'b0, bus.dma_ready}, {31'b0, own && bus.dma_valid});
        check("m_stall", {31'b0, bus.core_stall},
              {31'b0, own && (bus.core_read || bus.core_write)});
        check("m_mread", {31'b0, bus.mem_read}, {31'b0, e_rd});
        check("m_mwrite", {31'b0, bus.mem_write}, {31'b0, e_wr});
        if (e_rd || e_wr) begin
          check("m_maddr", bus.mem_addr, own ? bus.dma_addr : bus.core_addr);
          check("m_msize", {30'b0, bus.mem_size}, {30'b0, own ? MEM_WORD : bus.core_size});
        end
        if (e_wr) check("m_mwdata", bus.mem_wdata, own ? bus.dma_wdata : bus.core_wdata);
        if (bus.core_read)
          check("m_core_rdata", bus.core_rdata,
                own ? 32'h0 : ref_mem[bus.core_addr[9:2]]);
      end
      check("m_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, m_rvalid});
      check("m_rdata", bus.dma_rdata, m_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_in();
    bus.core_read = 0; bus.core_write = 0; bus.core_size = MEM_WORD;
    bus.core_unsigned = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.dma_valid = 0; bus.dma_we = 0; bus.dma_burst = 0; bus.dma_last = 0;
    bus.dma_addr = 0; bus.dma_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_beat(input logic we, input logic burst, input logic last,
                          input logic [31:0] addr, input logic [31:0] wd);
    bus.dma_valid = 1; bus.dma_we = we; bus.dma_burst = burst; bus.dma_last = last;
    bus.dma_addr = addr; bus.dma_wdata = wd;
  endtask

  initial begin
    int first_acc;
    int stalls;
    rst_n = 0;
    idle_in();
    bus.core_read = 1; bus.dma_valid = 1; bus.dma_addr = 32'h10;
    repeat (2) @(negedge clk);
    check("reset_mem_read", {31'b0, bus.mem_read}, 32'd0);
    check("reset_dma_ready", {31'b0, bus.dma_ready}, 32'd0);
    check("reset_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    step();
    rst_n = 1;
    @(negedge clk);
    check("post_reset_core_first", {31'b0, bus.core_stall}, 32'd0);
    check("post_reset_core_rd", {31'b0, bus.mem_read}, 32'd1);
    step();

    // single DMA read of 0x10
    idle_in();
    dma_beat(0, 0, 0, 32'h10, 0);
    @(negedge clk);
    check("dma_rd_ready", {31'b0, bus.dma_ready}, 32'd1);
    step();
    idle_in();
    @(negedge clk);
    check("dma_rd_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
    check("dma_rd_data", bus.dma_rdata, 32'hDEADBEEF);
    step();

    // back-to-back reads
    dma_beat(0, 0, 0, 32'h14, 0);
    step();
    dma_beat(0, 0, 0, 32'h18, 0);
    @(negedge clk);
    check("b2b_rvalid0", {31'b0, bus.dma_rvalid}, 32'd1);
    check("b2b_rdata0", bus.dma_rdata, 32'h10000005);
    step();
    idle_in();
    @(negedge clk);
    check("b2b_rvalid1", {31'b0, bus.dma_rvalid}, 32'd1);
    check("b2b_rdata1", bus.dma_rdata, 32'h10000006);
    step();
    step();

    // core load every cycle with a DMA read pending
    first_acc = 0;
    stalls = 0;
    for (int c = 1; c <= 6; c++) begin
      idle_in();
      bus.core_read = 1; bus.core_addr = 32'h20;
      if (first_acc == 0) dma_beat(0, 0, 0, 32'h30, 0);
      @(negedge clk);
      if (bus.dma_ready && first_acc == 0) first_acc = c;
      if (bus.core_stall) stalls++;
      step();
    end
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
    check("starve_accept_cycle", 32'(first_acc), 32'd5);
    check("starve_stall_count", 32'(stalls), 32'd1);
`else
    check("strict_no_accept", 32'(first_acc), 32'd0);
    check("strict_no_stall", 32'(stalls), 32'd0);
`endif
    idle_in();
    dma_beat(0, 0, 0, 32'h30, 0);
    @(negedge clk);
    check("core_idle_accept", {31'b0, bus.dma_ready}, 32'd1);
    step();
    idle_in();
    step();

    // 4-beat write burst, core store arriving on beat 2
    for (int i = 0; i < 4; i++) begin
      dma_beat(1, i == 0, i == 3, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      if (i >= 1) begin
        bus.core_write = 1; bus.core_addr = 32'h200; bus.core_wdata = 32'h55AA55AA;
      end
      @(negedge clk);
      check("burst_ready", {31'b0, bus.dma_ready}, 32'd1);
      if (i >= 1) check("burst_core_stall", {31'b0, bus.core_stall}, 32'd1);
      step();
    end
    bus.dma_valid = 0; bus.dma_last = 0;
    @(negedge clk);
    check("after_last_stall", {31'b0, bus.core_stall}, 32'd0);
    check("after_last_store", {31'b0, bus.mem_write}, 32'd1);
    step();
    idle_in();
    @(negedge clk);
    check("burst_mem0", tb_mem[64], 32'hA0000000);
    check("burst_mem1", tb_mem[65], 32'hA0000001);
    check("burst_mem2", tb_mem[66], 32'hA0000002);
    check("burst_mem3", tb_mem[67], 32'hA0000003);
    check("core_store_mem", tb_mem[128], 32'h55AA55AA);
    step();

    // burst with a two-cycle valid gap
    dma_beat(1, 1, 0, 32'h140, 32'hB0B0B0B0);
    step();
    idle_in();
    bus.core_read = 1; bus.core_addr = 32'h40;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("gap_stall", {31'b0, bus.core_stall}, 32'd1);
      check("gap_no_strobe", {31'b0, bus.mem_read}, 32'd0);
      step();
    end
    dma_beat(1, 0, 1, 32'h144, 32'hB1B1B1B1);
    @(negedge clk);
    check("gap_last_ready", {31'b0, bus.dma_ready}, 32'd1);
    step();
    bus.dma_valid = 0; bus.dma_last = 0;
    @(negedge clk);
    check("gap_released", {31'b0, bus.core_stall}, 32'd0);
    step();

    // reset in the middle of a read burst
    idle_in();
    dma_beat(0, 1, 0, 32'h10, 0);
    step();
    dma_beat(0, 0, 0, 32'h14, 0);
    bus.core_read = 1;
    #2 rst_n = 0;
    @(negedge clk);
    check("midrst_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    check("midrst_ready", {31'b0, bus.dma_ready}, 32'd0);
    step();
    rst_n = 1;
    bus.dma_valid = 0;
    @(negedge clk);
    check("midrst_aborted", {31'b0, bus.core_stall}, 32'd0);
    check("midrst_no_resp", {31'b0, bus.dma_rvalid}, 32'd0);
    step();
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
